fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end for the pipelined CPU, between program memory and decode. Issues one program-memory read per cycle under credit control, tracks in-flight reads through a fixed-latency shadow pipeline, and buffers returned instructions in a DEPTH-entry queue. Decode consumes them through the FetchAction handshake (Dequeue / Stall / Redirect). Redirect flushes both the queue and all in-flight reads in one cycle.

## Interface
- XLEN, 32: PC width in bits.
- IADDR_W, 14: program-memory word-address width.
- DEPTH, 4: instruction queue entries, power of two, ≥ 2.
- READ_LAT, 1: program-memory read latency in cycles, ≥ 1.
- RESET_PC, 0: first fetch address.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous, active-high reset.
- fetch_action_in  in  FetchAction  Dequeue, Stall or Redirect (from ProcTypes).
- redirect_pc_in  in  XLEN  target PC, used only on Redirect.
- pmem_req_out  out  1  read request this cycle.
- pmem_addr_out  out  IADDR_W  word address (pc[IADDR_W+1:2]).
- pmem_data_in  in  32  read data, valid exactly READ_LAT cycles after the request.
- f2d_valid_out  out  1  queue head valid.
- f2d_pc_out  out  XLEN  PC of the queue head.
- f2d_inst_out  out  32  instruction at the queue head.
- count_out  out  $clog2(DEPTH)+1  queue occupancy.

## Operation
- State:
  - fetch_pc register.
  - READ_LAT-deep shadow pipeline of {valid, pc}.
  - FIFO of {pc, inst}.
- Issue:
  - pmem_req_out = (count + inflight < DEPTH) and action ≠ Redirect.
  - inflight is the number of valid shadow stages.
  - On issue, fetch_pc ← fetch_pc + 4, wrapping modulo 2^XLEN, and {1, fetch_pc} enters the shadow pipeline.
- Return: when the shadow-pipeline output stage is valid, {pc, pmem_data_in} is pushed into the FIFO.
- Credit guarantees the FIFO never overflows. Dequeue in the same cycle is not credited.
- Dequeue: pops the head if the FIFO is non-empty. Dequeue on an empty FIFO is ignored.
- Stall: no pop. Issue and return continue while credit allows.
- Redirect, which takes precedence over everything:
  - FIFO is emptied and all shadow valid bits are cleared.
  - Any data returning in this cycle is discarded.
  - fetch_pc ← {redirect_pc_in[XLEN-1:2], 2'b00}.
  - No request is issued in the redirect cycle.
- Push and pop in the same cycle are both performed; count is unchanged.
- Responses are strictly in order. There are no tags beyond shadow-stage validity.

## Timing
- Reset (asynchronous, takes effect immediately), values held while rst_in is high:
  - fetch_pc = RESET_PC; shadow and FIFO empty.
  - f2d_valid_out = 0, f2d_pc_out = 0, f2d_inst_out = 0, count_out = 0.
  - pmem_req_out = 0, pmem_addr_out = 0.
- Issue begins in the first cycle after rst_in deasserts.
- Reset asserted mid-operation drops all queued and in-flight instructions. Memory data arriving afterwards is ignored.
- f2d outputs come straight from FIFO head registers. Decode sees them combinationally in the same cycle.
- Latency:
  - Request at cycle t → FIFO push at the end of cycle t+READ_LAT → f2d_valid_out in cycle t+READ_LAT+1.
  - Redirect at cycle r → first request at r+1 → new-path instruction visible at r+READ_LAT+2.
- Throughput: one instruction per cycle when DEPTH ≥ READ_LAT+2 and decode dequeues every cycle. Smaller DEPTH is legal but throttles issue.
- count_out reflects the registered occupancy (after last edge).

## Structure
- In ProcTypes:
  - FetchAction enum.
  - F2D struct {pc, inst, isValid}, widened to XLEN.
  - FETCH_RESET_PC constant.
- Sub-module fetch_fifo: synchronous FIFO, WIDTH = XLEN+32, DEPTH entries, with:
  - push, pop and flush inputs;
  - head and count outputs;
  - asynchronous reset.
- fetch_queue itself holds fetch_pc, the shadow pipeline, credit logic and action decode.

## Test plan
- Reset release, READ_LAT=1, DEPTH=4, constant Dequeue, memory word k = k:
  - requests to addresses 0, 1, 2, … on consecutive cycles;
  - f2d_valid_out first high at cycle 2 with pc 0, inst 0;
  - then pc +4 per cycle, no bubbles.
- Stall held 10 cycles from reset:
  - exactly 4 requests issued; count_out saturates at 4; pmem_req_out stays 0 while full;
  - after one Dequeue, count_out returns to 4 after READ_LAT+1 cycles.
- Redirect to 0x0000_0102 with 2 in flight and 3 queued, READ_LAT=2:
  - f2d_valid_out 0 next cycle and count_out 0; in-flight data is dropped;
  - next request address 0x40; first valid pc 0x100 at r+4.
- Redirect on two consecutive cycles, targets 0x20 then 0x80: only the 0x80 stream ever appears at f2d.
- fetch_pc at 0xFFFF_FFFC with Dequeue: next pc 0x0000_0000, issued in order.
- rst_in pulsed mid-stream, asynchronously and between edges:
  - outputs zero immediately;
  - a response pending at reset is never pushed;
  - fetch restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared fetch front-end types: decode action encoding,
// the fetch-to-decode bundle and the reset PC.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    FA_DEQUEUE  = 2'd0,
    FA_STALL    = 2'd1,
    FA_REDIRECT = 2'd2
  } fetch_action_e;

  localparam int F2D_XLEN = 32;

  localparam logic [F2D_XLEN-1:0] FETCH_RESET_PC = '0;

  typedef struct packed {
    logic [F2D_XLEN-1:0] pc;
    logic [31:0]         inst;
    logic                is_valid;
  } f2d_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO holding {pc, inst} entries,
// with single-cycle flush and a registered head.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic             flush_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] head_out,
  output logic [CW-1:0]    count_out
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = push_in & (count_q != CW'(DEPTH));
    pop_ok   = pop_in & (count_q != '0);
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = data_in;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_out  = mem_q[rd_ptr_q];
  assign count_out = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited issue, fixed-latency
// shadow pipeline for in-flight reads, and the decode-side queue.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IADDR_W = 14,
  parameter int DEPTH = 4,
  parameter int READ_LAT = 1,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  fetch_action_e      fetch_action_in,
  input  logic [XLEN-1:0]    redirect_pc_in,
  output logic               pmem_req_out,
  output logic [IADDR_W-1:0] pmem_addr_out,
  input  logic [31:0]        pmem_data_in,
  output logic               f2d_valid_out,
  output logic [XLEN-1:0]    f2d_pc_out,
  output logic [31:0]        f2d_inst_out,
  output logic [CW-1:0]      count_out
);

  localparam int SW = $clog2(DEPTH + READ_LAT + 1) + 1;
  localparam int FW = XLEN + 32;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [READ_LAT-1:0] sh_vld_q, sh_vld_d;
  logic [READ_LAT-1:0][XLEN-1:0] sh_pc_q, sh_pc_d;

  logic          is_redir;
  logic          is_deq;
  logic [SW-1:0] inflight;
  logic          credit;
  logic          req;
  logic          push;
  logic          pop;
  logic [FW-1:0] head;
  logic [CW-1:0] fifo_count;

  always_comb begin
    is_redir = 1'b0;
    is_deq   = 1'b0;
    unique case (1'b1)
      (fetch_action_in == FA_REDIRECT): is_redir = 1'b1;
      (fetch_action_in == FA_DEQUEUE):  is_deq   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      inflight = inflight + SW'(sh_vld_q[i]);
    end
  end

  // Same-cycle pops are not credited: occupancy is the registered count.
  assign credit = (SW'(fifo_count) + inflight) < SW'(DEPTH);
  assign req    = credit & ~is_redir & ~rst_in;
  assign push   = sh_vld_q[READ_LAT-1] & ~is_redir;
  assign pop    = is_deq & (fifo_count != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (is_redir) begin
      fetch_pc_d = redirect_pc_in & ~XLEN'(3);
    end else if (req) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

  always_comb begin
    sh_vld_d    = sh_vld_q;
    sh_pc_d     = sh_pc_q;
    sh_vld_d[0] = req;
    sh_pc_d[0]  = fetch_pc_q;
    for (int i = 1; i < READ_LAT; i++) begin
      sh_vld_d[i] = sh_vld_q[i-1];
      sh_pc_d[i]  = sh_pc_q[i-1];
    end
    if (is_redir) begin
      sh_vld_d = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fetch_pc_q <= RESET_PC;
      sh_vld_q   <= '0;
      sh_pc_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      sh_vld_q   <= sh_vld_d;
      sh_pc_q    <= sh_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (push),
    .pop_in    (pop),
    .flush_in  (is_redir),
    .data_in   ({sh_pc_q[READ_LAT-1], pmem_data_in}),
    .head_out  (head),
    .count_out (fifo_count)
  );

  assign pmem_req_out  = req;
  assign pmem_addr_out = rst_in ? '0 : fetch_pc_q[IADDR_W+1:2];
  assign count_out     = fifo_count;
  assign f2d_valid_out = fifo_count != '0;
  assign f2d_pc_out    = f2d_valid_out ? head[FW-1:32] : '0;
  assign f2d_inst_out  = f2d_valid_out ? head[31:0] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: one READ_LAT=1/DEPTH=4 instance
// and one READ_LAT=2/DEPTH=8 instance against a word-k=k memory.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_action_e act1 = FA_STALL;
  fetch_action_e act2 = FA_STALL;
  logic [31:0] rpc1 = '0;
  logic [31:0] rpc2 = '0;

  logic        req1, req2;
  logic [13:0] addr1, addr2;
  logic [31:0] data1, data2;
  logic        v1, v2;
  logic [31:0] pc1, pc2;
  logic [31:0] inst1, inst2;
  logic [2:0]  cnt1;
  logic [3:0]  cnt2;

  logic [31:0] m2_a;

  always @(posedge clk) begin
    data1 <= {18'b0, addr1};
    m2_a  <= {18'b0, addr2};
    data2 <= m2_a;
  end

  fetch_queue #(
    .XLEN(32), .IADDR_W(14), .DEPTH(4), .READ_LAT(1), .RESET_PC(32'h0)
  ) u1 (
    .clk_in          (clk),
    .rst_in          (rst),
    .fetch_action_in (act1),
    .redirect_pc_in  (rpc1),
    .pmem_req_out    (req1),
    .pmem_addr_out   (addr1),
    .pmem_data_in    (data1),
    .f2d_valid_out   (v1),
    .f2d_pc_out      (pc1),
    .f2d_inst_out    (inst1),
    .count_out       (cnt1)
  );

  fetch_queue #(
    .XLEN(32), .IADDR_W(14), .DEPTH(8), .READ_LAT(2), .RESET_PC(32'h0)
  ) u2 (
    .clk_in          (clk),
    .rst_in          (rst),
    .fetch_action_in (act2),
    .redirect_pc_in  (rpc2),
    .pmem_req_out    (req2),
    .pmem_addr_out   (addr2),
    .pmem_data_in    (data2),
    .f2d_valid_out   (v2),
    .f2d_pc_out      (pc2),
    .f2d_inst_out    (inst2),
    .count_out       (cnt2)
  );

  int n_chk = 0;
  int n_fail = 0;
  int nreq;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req", 64'(req1), 64'(0));
    check("rst addr", 64'(addr1), 64'(0));
    check("rst valid", 64'(v1), 64'(0));
    check("rst pc", 64'(pc1), 64'(0));
    check("rst inst", 64'(inst1), 64'(0));
    check("rst count", 64'(cnt1), 64'(0));

    // streaming with constant dequeue
    @(posedge clk);
    #1 rst = 1'b0;
    act1 = FA_DEQUEUE;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t1 req", 64'(req1), 64'(1));
      check("t1 addr", 64'(addr1), 64'(c));
      check("t1 valid", 64'(v1), 64'(c >= 2));
      if (c >= 2) begin
        check("t1 pc", 64'(pc1), 64'(4 * (c - 2)));
        check("t1 inst", 64'(inst1), 64'(c - 2));
      end
      tick();
    end

    // stall from reset fills the queue
    act1 = FA_STALL;
    do_reset();
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req1) nreq++;
      if (c >= 4) check("t2 req full", 64'(req1), 64'(0));
      tick();
    end
    check("t2 nreq", 64'(nreq), 64'(4));
    check("t2 count", 64'(cnt1), 64'(4));
    check("t2 head pc", 64'(pc1), 64'(0));
    act1 = FA_DEQUEUE;
    @(negedge clk);
    check("t2 deq nocredit", 64'(req1), 64'(0));
    tick();
    act1 = FA_STALL;
    @(negedge clk);
    check("t2 cnt after pop", 64'(cnt1), 64'(3));
    check("t2 pc after pop", 64'(pc1), 64'(4));
    check("t2 inst after pop", 64'(inst1), 64'(1));
    check("t2 refill req", 64'(req1), 64'(1));
    tick();
    @(negedge clk);
    check("t2 cnt r+1", 64'(cnt1), 64'(3));
    tick();
    @(negedge clk);
    check("t2 cnt refilled", 64'(cnt1), 64'(4));

    // redirect with 3 queued and 2 in flight
    tick();
    act2 = FA_STALL;
    do_reset();
    repeat (5) tick();
    act2 = FA_REDIRECT;
    rpc2 = 32'h0000_0102;
    @(negedge clk);
    check("t3 count pre", 64'(cnt2), 64'(3));
    check("t3 req redir", 64'(req2), 64'(0));
    tick();
    act2 = FA_DEQUEUE;
    @(negedge clk);
    check("t3 valid r+1", 64'(v2), 64'(0));
    check("t3 count r+1", 64'(cnt2), 64'(0));
    check("t3 req r+1", 64'(req2), 64'(1));
    check("t3 addr r+1", 64'(addr2), 64'(14'h40));
    tick();
    @(negedge clk);
    check("t3 addr r+2", 64'(addr2), 64'(14'h41));
    check("t3 valid r+2", 64'(v2), 64'(0));
    tick();
    @(negedge clk);
    check("t3 valid r+3", 64'(v2), 64'(0));
    tick();
    @(negedge clk);
    check("t3 valid r+4", 64'(v2), 64'(1));
    check("t3 pc r+4", 64'(pc2), 64'(32'h100));
    check("t3 inst r+4", 64'(inst2), 64'(32'h40));
    tick();
    @(negedge clk);
    check("t3 pc r+5", 64'(pc2), 64'(32'h104));
    check("t3 inst r+5", 64'(inst2), 64'(32'h41));

    // back-to-back redirects: only the second target survives
    tick();
    act2 = FA_REDIRECT;
    rpc2 = 32'h20;
    tick();
    rpc2 = 32'h80;
    tick();
    act2 = FA_DEQUEUE;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("t4 valid", 64'(v2), 64'(k >= 4));
      check("t4 pc", 64'(pc2), 64'((k >= 4) ? 32'h80 + 4 * (k - 4) : 0));
      check("t4 inst", 64'(inst2), 64'((k >= 4) ? 32'h20 + (k - 4) : 0));
      tick();
    end

    // PC wrap at the top of the address space
    act1 = FA_REDIRECT;
    rpc1 = 32'hFFFF_FFFC;
    tick();
    act1 = FA_DEQUEUE;
    @(negedge clk);
    check("t5 req", 64'(req1), 64'(1));
    check("t5 addr top", 64'(addr1), 64'(14'h3FFF));
    tick();
    @(negedge clk);
    check("t5 addr wrap", 64'(addr1), 64'(0));
    tick();
    @(negedge clk);
    check("t5 valid", 64'(v1), 64'(1));
    check("t5 pc top", 64'(pc1), 64'(32'hFFFF_FFFC));
    check("t5 inst top", 64'(inst1), 64'(32'h3FFF));
    tick();
    @(negedge clk);
    check("t5 pc wrap", 64'(pc1), 64'(0));
    check("t5 inst wrap", 64'(inst1), 64'(0));

    // asynchronous reset mid-stream
    tick();
    #2 rst = 1'b1;
    #1;
    check("t6 valid", 64'(v1), 64'(0));
    check("t6 pc", 64'(pc1), 64'(0));
    check("t6 inst", 64'(inst1), 64'(0));
    check("t6 count", 64'(cnt1), 64'(0));
    check("t6 req", 64'(req1), 64'(0));
    check("t6 addr", 64'(addr1), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6 c0 count", 64'(cnt1), 64'(0));
    check("t6 c0 addr", 64'(addr1), 64'(0));
    check("t6 c0 req", 64'(req1), 64'(1));
    tick();
    @(negedge clk);
    check("t6 c1 valid", 64'(v1), 64'(0));
    check("t6 c1 count", 64'(cnt1), 64'(0));
    tick();
    @(negedge clk);
    check("t6 c2 valid", 64'(v1), 64'(1));
    check("t6 c2 pc", 64'(pc1), 64'(0));
    check("t6 c2 inst", 64'(inst1), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
